// File: rtl/tl_ram.sv
// Single-port RAM slave on a TileLink-UL style A/D bus: Get, PutFullData and
// PutPartialData with lane masks, request checking and a one-deep response register.
module tl_ram #(
    parameter int    DATA_W    = 32,
    parameter int    ADDR_W    = 14,
    parameter int    DEPTH     = 4096,
    parameter int    SRC_W     = 2,
    parameter string INIT_FILE = ""
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                a_valid_i,
    output logic                a_ready_o,
    input  logic [2:0]          a_opcode_i,
    input  logic [1:0]          a_size_i,
    input  logic [SRC_W-1:0]    a_source_i,
    input  logic [ADDR_W-1:0]   a_address_i,
    input  logic [DATA_W/8-1:0] a_mask_i,
    input  logic [DATA_W-1:0]   a_data_i,
    output logic                d_valid_o,
    input  logic                d_ready_i,
    output logic [2:0]          d_opcode_o,
    output logic [1:0]          d_size_o,
    output logic [SRC_W-1:0]    d_source_o,
    output logic                d_error_o,
    output logic [DATA_W-1:0]   d_data_o
);

    localparam int LANES  = DATA_W / 8;
    localparam int OFF_W  = $clog2(LANES);
    localparam int IDX_W  = ADDR_W - OFF_W;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [2:0] OP_PUT_FULL = 3'd0;
    localparam logic [2:0] OP_PUT_PART = 3'd1;
    localparam logic [2:0] OP_GET      = 3'd4;
    localparam logic [2:0] OP_ACK      = 3'd0;
    localparam logic [2:0] OP_ACK_DATA = 3'd1;

    // Lanes a full-width Put of 2^size bytes must enable, starting at the lane offset.
    function automatic logic [LANES-1:0] span_mask(input logic [OFF_W-1:0] off,
                                                   input logic [1:0]       size);
        logic [LANES-1:0] m;
        int               lo;
        int               n;
        m  = '0;
        lo = int'(off);
        n  = 1 << size;
        for (int i = 0; i < LANES; i++) begin
            if (i >= lo && i < lo + n) m[i] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic is_misaligned(input logic [OFF_W-1:0] off,
                                           input logic [1:0]       size);
        int n;
        n = 1 << size;
        return (int'(off) & (n - 1)) != 0;
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    // Stage p0: request decode and checks on the A channel
    logic [OFF_W-1:0]  off_p0;
    logic [IDX_W-1:0]  word_idx_p0;
    logic [MEM_AW-1:0] mem_idx_p0;
    logic              is_get_p0;
    logic              is_put_p0;
    logic              err_p0;
    logic              accept_p0;
    logic              wr_en_p0;

    always_comb begin
        off_p0      = a_address_i[OFF_W-1:0];
        word_idx_p0 = a_address_i[ADDR_W-1:OFF_W];
        mem_idx_p0  = MEM_AW'(word_idx_p0);
        is_get_p0   = (a_opcode_i == OP_GET);
        is_put_p0   = (a_opcode_i == OP_PUT_FULL) || (a_opcode_i == OP_PUT_PART);
        err_p0      = 1'b0;
        if (!is_get_p0 && !is_put_p0)                 err_p0 = 1'b1;
        if (int'(a_size_i) > OFF_W)                   err_p0 = 1'b1;
        if (is_misaligned(off_p0, a_size_i))          err_p0 = 1'b1;
        if (64'(word_idx_p0) >= 64'(DEPTH))           err_p0 = 1'b1;
        if (a_opcode_i == OP_PUT_FULL && a_mask_i != span_mask(off_p0, a_size_i))
            err_p0 = 1'b1;
        if (is_put_p0 && a_mask_i == '0)              err_p0 = 1'b1;
    end

    assign a_ready_o = !rst_i && (!d_valid_o || d_ready_i);
    assign accept_p0 = a_valid_i && a_ready_o;
    assign wr_en_p0  = accept_p0 && is_put_p0 && !err_p0;

    always_ff @(posedge clk_i) begin
        if (wr_en_p0) begin
            for (int i = 0; i < LANES; i++) begin
                if (a_mask_i[i]) mem[mem_idx_p0][i*8 +: 8] <= a_data_i[i*8 +: 8];
            end
        end
    end

    // Stage p1: registered D-channel response
    logic              vld_p1;
    logic [2:0]        opcode_p1;
    logic [1:0]        size_p1;
    logic [SRC_W-1:0]  source_p1;
    logic              err_p1;
    logic              rdata_sel_p1;
    logic [DATA_W-1:0] rdata_p1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_p1       <= 1'b0;
            opcode_p1    <= OP_ACK;
            size_p1      <= '0;
            source_p1    <= '0;
            err_p1       <= 1'b0;
            rdata_sel_p1 <= 1'b0;
        end else if (accept_p0) begin
            vld_p1       <= 1'b1;
            opcode_p1    <= is_get_p0 ? OP_ACK_DATA : OP_ACK;
            size_p1      <= a_size_i;
            source_p1    <= a_source_i;
            err_p1       <= err_p0;
            rdata_sel_p1 <= is_get_p0 && !err_p0;
        end else if (d_ready_i) begin
            vld_p1       <= 1'b0;
        end
    end

    // Read data is captured on every accept; the select flag zeroes it for Put/error.
    always_ff @(posedge clk_i) begin
        if (accept_p0) rdata_p1 <= mem[mem_idx_p0];
    end

    assign d_valid_o  = vld_p1;
    assign d_opcode_o = opcode_p1;
    assign d_size_o   = size_p1;
    assign d_source_o = source_p1;
    assign d_error_o  = err_p1;
    assign d_data_o   = rdata_sel_p1 ? rdata_p1 : '0;

endmodule
